// File: rtl/nixie_reader_pkg.sv
// Shared constants for the two-digit nixie segment bus: the sixteen hex
// digit patterns (segment a..g, a in bit 0), the blank pattern, the digit
// select codes and the reader's state type.
package nixie_reader_pkg;

    localparam logic [0:6] NIXIE_BLANK   = 7'b0000000;

    localparam logic [0:6] NIXIE_DIGIT_0 = 7'b1111110;
    localparam logic [0:6] NIXIE_DIGIT_1 = 7'b0110000;
    localparam logic [0:6] NIXIE_DIGIT_2 = 7'b1101101;
    localparam logic [0:6] NIXIE_DIGIT_3 = 7'b1111001;
    localparam logic [0:6] NIXIE_DIGIT_4 = 7'b0110011;
    localparam logic [0:6] NIXIE_DIGIT_5 = 7'b1011011;
    localparam logic [0:6] NIXIE_DIGIT_6 = 7'b1011111;
    localparam logic [0:6] NIXIE_DIGIT_7 = 7'b1110000;
    localparam logic [0:6] NIXIE_DIGIT_8 = 7'b1111111;
    localparam logic [0:6] NIXIE_DIGIT_9 = 7'b1111011;
    localparam logic [0:6] NIXIE_DIGIT_A = 7'b1110111;
    localparam logic [0:6] NIXIE_DIGIT_B = 7'b0011111;
    localparam logic [0:6] NIXIE_DIGIT_C = 7'b1001110;
    localparam logic [0:6] NIXIE_DIGIT_D = 7'b0111101;
    localparam logic [0:6] NIXIE_DIGIT_E = 7'b1001111;
    localparam logic [0:6] NIXIE_DIGIT_F = 7'b1000111;

    // Digit 1 carries the high nibble, digit 0 the low nibble.
    localparam logic [1:0] NIXIE_SEL_HI  = 2'b10;
    localparam logic [1:0] NIXIE_SEL_LO  = 2'b01;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_OUT     = 1'b1
    } reader_state_e;

endpackage

// File: rtl/nixie_seg_decode.sv
// Combinational decode of a 7-segment pattern back to its hex nibble.
// Anything outside the sixteen digit patterns is flagged as not legal;
// the blank pattern is reported separately so it can be ignored silently.
module nixie_seg_decode
    import nixie_reader_pkg::*;
(
    input  logic [0:6] seg,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       blank
);

    // Pattern lookup; unknown patterns fall through to not-legal.
    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        blank  = (seg == NIXIE_BLANK);
        case (seg)
            NIXIE_DIGIT_0: nibble = 4'h0;
            NIXIE_DIGIT_1: nibble = 4'h1;
            NIXIE_DIGIT_2: nibble = 4'h2;
            NIXIE_DIGIT_3: nibble = 4'h3;
            NIXIE_DIGIT_4: nibble = 4'h4;
            NIXIE_DIGIT_5: nibble = 4'h5;
            NIXIE_DIGIT_6: nibble = 4'h6;
            NIXIE_DIGIT_7: nibble = 4'h7;
            NIXIE_DIGIT_8: nibble = 4'h8;
            NIXIE_DIGIT_9: nibble = 4'h9;
            NIXIE_DIGIT_A: nibble = 4'hA;
            NIXIE_DIGIT_B: nibble = 4'hB;
            NIXIE_DIGIT_C: nibble = 4'hC;
            NIXIE_DIGIT_D: nibble = 4'hD;
            NIXIE_DIGIT_E: nibble = 4'hE;
            NIXIE_DIGIT_F: nibble = 4'hF;
            default:       legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/nixie_reader.sv
// Receiver for the time-multiplexed two-digit segment bus. Each digit's
// pattern must be seen unchanged for STABLE_CYCLES samples before it is
// captured; the two captured nibbles are then presented as one byte on a
// valid/ready handshake. Reset is asynchronous and active-low.
module nixie_reader
    import nixie_reader_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:6] seg_i,
    input  logic [1:0] dig_sel_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       err_o
);

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [0:6]    prev_seg_q, prev_seg_d;
    logic [1:0]    prev_sel_q, prev_sel_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [3:0]    hi_q, hi_d, lo_q, lo_d;
    logic          hi_flag_q, hi_flag_d, lo_flag_q, lo_flag_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    reader_state_e state_q, state_d;

    logic          sel_one_hot;
    logic          same_sample;
    logic          capture;
    logic [3:0]    dec_nibble;
    logic          dec_legal;
    logic          dec_blank;

    nixie_seg_decode u_decode (
        .seg    (seg_i),
        .nibble (dec_nibble),
        .legal  (dec_legal),
        .blank  (dec_blank)
    );

    // Stability window: count identical samples, restart on any change or select glitch.
    always_comb begin
        sel_one_hot = (dig_sel_i == NIXIE_SEL_HI) || (dig_sel_i == NIXIE_SEL_LO);
        same_sample = (dig_sel_i == prev_sel_q) && (seg_i == prev_seg_q);
        prev_seg_d  = prev_seg_q;
        prev_sel_d  = prev_sel_q;
        cnt_d       = cnt_q;
        if (!sel_one_hot) begin
            cnt_d      = 8'd0;
            prev_sel_d = dig_sel_i;
        end else if (!same_sample) begin
            cnt_d      = 8'd1;
            prev_sel_d = dig_sel_i;
            prev_seg_d = seg_i;
        end else if (cnt_q < STABLE_LIM) begin
            cnt_d = cnt_q + 8'd1;
        end
        capture = sel_one_hot && same_sample && (cnt_q == STABLE_LIM - 8'd1);
    end

    // Byte assembly and handshake; a capture is applied after any flag clear so it wins.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        hi_flag_d = hi_flag_q;
        lo_flag_d = lo_flag_q;
        data_d    = data_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        state_d   = state_q;
        case (state_q)
            ST_COLLECT: begin
                if (hi_flag_q && lo_flag_q) begin
                    data_d    = {hi_q, lo_q};
                    valid_d   = 1'b1;
                    hi_flag_d = 1'b0;
                    lo_flag_d = 1'b0;
                    state_d   = ST_OUT;
                end
            end
            ST_OUT: begin
                if (valid_q && ready_i) begin
                    if (hi_flag_q && lo_flag_q) begin
                        data_d    = {hi_q, lo_q};
                        hi_flag_d = 1'b0;
                        lo_flag_d = 1'b0;
                    end else begin
                        valid_d = 1'b0;
                        state_d = ST_COLLECT;
                    end
                end
            end
            default: state_d = ST_COLLECT;
        endcase
        if (capture) begin
            if (dec_legal) begin
                if (dig_sel_i == NIXIE_SEL_HI) begin
                    hi_d      = dec_nibble;
                    hi_flag_d = 1'b1;
                end else begin
                    lo_d      = dec_nibble;
                    lo_flag_d = 1'b1;
                end
            end else if (!dec_blank) begin
                err_d = 1'b1;
            end
        end
    end

    // State registers; reset discards any partially assembled byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_seg_q <= 7'b0000000;
            prev_sel_q <= 2'b00;
            cnt_q      <= 8'd0;
            hi_q       <= 4'h0;
            lo_q       <= 4'h0;
            hi_flag_q  <= 1'b0;
            lo_flag_q  <= 1'b0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            state_q    <= ST_COLLECT;
        end else begin
            prev_seg_q <= prev_seg_d;
            prev_sel_q <= prev_sel_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            hi_flag_q  <= hi_flag_d;
            lo_flag_q  <= lo_flag_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            state_q    <= state_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_nixie_reader.sv
// Bench for nixie_reader with STABLE_CYCLES = 4: directed scenarios from
// the digit rules plus a randomized stream of bytes checked against an
// expected-byte queue.
module tb_nixie_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:6] seg;
    logic [1:0] sel;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       err;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int err_seen   = 0;
    int valid_seen = 0;

    logic [0:6] pat [16];
    logic [7:0] got [$];
    logic [7:0] exp_q [$];

    localparam logic [1:0] HI = 2'b10;
    localparam logic [1:0] LO = 2'b01;

    nixie_reader #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_i     (seg),
        .dig_sel_i (sel),
        .data_o    (data),
        .valid_o   (valid),
        .ready_i   (ready),
        .err_o     (err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // One clock edge; record handshakes taken at that edge and outputs after it.
    task automatic tick();
        if (valid && ready) got.push_back(data);
        @(posedge clk);
        #1;
        if (err) err_seen++;
        if (valid) valid_seen++;
    endtask

    task automatic hold(input logic [1:0] s, input logic [0:6] p, input int n);
        sel = s;
        seg = p;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sel = 2'b00;
        seg = 7'b0000000;
        ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        got.delete();
        exp_q.delete();
        err_seen = 0;
        valid_seen = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seg = 7'($urandom);
            sel = 2'($urandom);
            ready = 1'($urandom);
            @(posedge clk);
            #1;
            assert_cnt++;
            if (data !== 8'h00) begin fail_cnt++; $display("[TB] FAIL reset_data: data_o=%h required 00", data); end
            assert_cnt++;
            if (valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_valid: valid_o=%b required 0", valid); end
            assert_cnt++;
            if (err !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_err: err_o=%b required 0", err); end
        end
        rst = 1'b1;
        ready = 1'b1;
        hold(HI, pat[5], 4);
        hold(LO, pat[10], 2);
        #2 rst = 1'b0;
        #1;
        assert_cnt++;
        if (valid !== 1'b0 || data !== 8'h00) begin
            fail_cnt++; $display("[TB] FAIL reset_async: valid_o=%b data_o=%h required 0/00", valid, data);
        end
        rst = 1'b1;
        valid_seen = 0;
        hold(LO, pat[10], 8);
        assert_cnt++;
        if (valid_seen !== 0) begin fail_cnt++; $display("[TB] FAIL reset_partial: valid cycles=%0d required 0", valid_seen); end
    endtask

    task automatic test_basic();
        do_reset();
        ready = 1'b1;
        hold(HI, pat[5], 4);
        valid_seen = 0;
        hold(LO, pat[10], 4);
        assert_cnt++;
        if (valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL basic_early: valid_o=%b required 0", valid); end
        tick();
        assert_cnt++;
        if (valid !== 1'b1 || data !== 8'h5A) begin
            fail_cnt++; $display("[TB] FAIL basic_byte: valid_o=%b data_o=%h required 1/5a", valid, data);
        end
        hold(LO, pat[10], 6);
        assert_cnt++;
        if (valid_seen !== 1) begin fail_cnt++; $display("[TB] FAIL basic_pulse: valid cycles=%0d required 1", valid_seen); end
    endtask

    task automatic test_debounce();
        do_reset();
        ready = 1'b1;
        hold(LO, pat[0], 4);
        for (int r = 0; r < 5; r++) hold(HI, (r % 2 == 0) ? pat[0] : pat[1], 3);
        hold(2'b00, pat[1], 1);
        assert_cnt++;
        if (valid_seen !== 0) begin fail_cnt++; $display("[TB] FAIL debounce_bounce: valid cycles=%0d required 0", valid_seen); end
        hold(HI, pat[1], 4);
        tick();
        assert_cnt++;
        if (valid !== 1'b1 || data !== 8'h10) begin
            fail_cnt++; $display("[TB] FAIL debounce_byte: valid_o=%b data_o=%h required 1/10", valid, data);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        ready = 1'b1;
        hold(LO, 7'b1010101, 3);
        tick();
        assert_cnt++;
        if (err !== 1'b1) begin fail_cnt++; $display("[TB] FAIL illegal_pulse: err_o=%b required 1", err); end
        hold(LO, 7'b1010101, 5);
        assert_cnt++;
        if (err_seen !== 1) begin fail_cnt++; $display("[TB] FAIL illegal_count: err pulses=%0d required 1", err_seen); end
        hold(HI, pat[3], 6);
        assert_cnt++;
        if (valid_seen !== 0) begin fail_cnt++; $display("[TB] FAIL illegal_noflag: valid cycles=%0d required 0", valid_seen); end
        hold(LO, 7'b0000000, 10);
        assert_cnt++;
        if (err_seen !== 1 || valid_seen !== 0) begin
            fail_cnt++; $display("[TB] FAIL blank_ignored: err pulses=%0d valid cycles=%0d required 1/0", err_seen, valid_seen);
        end
        hold(LO, pat[4], 5);
        assert_cnt++;
        if (valid !== 1'b1 || data !== 8'h34) begin
            fail_cnt++; $display("[TB] FAIL illegal_recover: valid_o=%b data_o=%h required 1/34", valid, data);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 1'b0;
        hold(HI, pat[3], 4);
        hold(LO, pat[12], 5);
        assert_cnt++;
        if (valid !== 1'b1 || data !== 8'h3C) begin
            fail_cnt++; $display("[TB] FAIL bp_first: valid_o=%b data_o=%h required 1/3c", valid, data);
        end
        hold(HI, pat[7], 4);
        assert_cnt++;
        if (valid !== 1'b1 || data !== 8'h3C) begin
            fail_cnt++; $display("[TB] FAIL bp_hold: valid_o=%b data_o=%h required 1/3c", valid, data);
        end
        hold(LO, pat[14], 4);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        assert_cnt++;
        if (valid !== 1'b1 || data !== 8'h7E) begin
            fail_cnt++; $display("[TB] FAIL bp_b2b: valid_o=%b data_o=%h required 1/7e", valid, data);
        end
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        assert_cnt++;
        if (valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL bp_drain: valid_o=%b required 0", valid); end
        assert_cnt++;
        if (got.size() != 2 || got[0] !== 8'h3C || got[1] !== 8'h7E) begin
            fail_cnt++; $display("[TB] FAIL bp_order: accepted %0d bytes, required 3c then 7e", got.size());
        end
    endtask

    task automatic test_overwrite_glitch();
        do_reset();
        ready = 1'b1;
        hold(HI, pat[2], 4);
        hold(HI, pat[9], 4);
        hold(LO, pat[0], 2);
        hold(2'b11, pat[0], 1);
        hold(LO, pat[0], 4);
        assert_cnt++;
        if (valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL glitch_early: valid_o=%b required 0", valid); end
        tick();
        assert_cnt++;
        if (valid !== 1'b1 || data !== 8'h90) begin
            fail_cnt++; $display("[TB] FAIL overwrite_byte: valid_o=%b data_o=%h required 1/90", valid, data);
        end
    endtask

    task automatic test_random();
        int h;
        int l;
        int k;
        logic [7:0] b;
        do_reset();
        for (int it = 0; it < 10; it++) begin
            h = $urandom_range(0, 15);
            l = $urandom_range(0, 15);
            b = 8'((h << 4) | l);
            hold(HI, pat[h], $urandom_range(4, 7));
            hold(2'b00, pat[$urandom_range(0, 15)], $urandom_range(0, 2));
            sel = LO;
            seg = pat[l];
            for (int n = $urandom_range(4, 7); n > 0; n--) begin
                ready = 1'($urandom);
                tick();
            end
            exp_q.push_back(b);
            k = 0;
            while (got.size() < exp_q.size() && k < 40) begin
                ready = (k >= 3) ? 1'b1 : 1'($urandom);
                tick();
                k++;
            end
            ready = 1'b0;
            assert_cnt++;
            if (got.size() != exp_q.size()) begin
                fail_cnt++; $display("[TB] FAIL random_count: accepted %0d bytes required %0d", got.size(), exp_q.size());
                break;
            end
            assert_cnt++;
            if (got[it] !== exp_q[it]) begin
                fail_cnt++; $display("[TB] FAIL random_byte%0d: data_o=%h required %h", it, got[it], exp_q[it]);
            end
        end
        assert_cnt++;
        if (err_seen !== 0) begin fail_cnt++; $display("[TB] FAIL random_err: err pulses=%0d required 0", err_seen); end
    endtask

    // Hard stop in case something hangs despite the bounded loops.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence.
    initial begin
        pat[0]  = 7'b1111110; pat[1]  = 7'b0110000; pat[2]  = 7'b1101101; pat[3]  = 7'b1111001;
        pat[4]  = 7'b0110011; pat[5]  = 7'b1011011; pat[6]  = 7'b1011111; pat[7]  = 7'b1110000;
        pat[8]  = 7'b1111111; pat[9]  = 7'b1111011; pat[10] = 7'b1110111; pat[11] = 7'b0011111;
        pat[12] = 7'b1001110; pat[13] = 7'b0111101; pat[14] = 7'b1001111; pat[15] = 7'b1000111;
        rst = 1'b0;
        seg = 7'b0000000;
        sel = 2'b00;
        ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_debounce();
        test_illegal();
        test_backpressure();
        test_overwrite_glitch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
